mlp_sequencer: RTL and testbench

MLP_SEQUENCER -- requirements
Module: mlp_sequencer

---
 rtl/mlp_pkg.sv | 26 ++
 rtl/mlp_sequencer_wrap_counter.sv | 31 +++
 rtl/mlp_sequencer.sv | 138 +++++++++++++
 tb/tb_mlp_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared defaults, output widths and the sequencer state encoding for the MLP sequencer.
package mlp_pkg;
    localparam int N_IN_DEF  = 784;
    localparam int N_HID_DEF = 200;
    localparam int N_OUT_DEF = 10;
    localparam int DRAIN_DEF = 4;

    localparam int A1_W  = 18;
    localparam int A2_W  = 12;
    localparam int A3_W  = 10;
    localparam int HID_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1,
        S_DRAIN1,
        S_L2,
        S_DRAIN2,
        S_DONE
    } state_e;

    // Counter width for a modulus, never below one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/mlp_sequencer_wrap_counter.sv
// Enabled modulo-MOD counter; wrap_o flags the terminal count so callers can chain counters.
module wrap_counter #(
    parameter int MOD = 4,
    parameter int W   = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = (cnt_q == W'(MOD - 1));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mlp_sequencer.sv
// Two-layer MLP inference sequencer: walks weight/activation SRAM addresses for layer 1
// then layer 2, with pipeline drain gaps, stall freeze and a one-cycle done pulse.
module mlp_sequencer
    import mlp_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_HID = N_HID_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int DRAIN = DRAIN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              layer_sel,
    output logic [A1_W-1:0]   address_1,
    output logic [A3_W-1:0]   address_3,
    output logic [A2_W-1:0]   address_2,
    output logic [HID_W-1:0]  hid_addr,
    output logic              mac_start,
    output logic              we_1,
    output logic              we_2,
    output logic              we_3
);
    localparam int IW = cnt_w(N_HID);
    localparam int KW = cnt_w(N_OUT);
    localparam int DW = cnt_w(DRAIN);

    state_e state_q, state_d;

    logic [A1_W-1:0]  addr1_q, addr1_d;
    logic [A2_W-1:0]  addr2_q, addr2_d;
    logic [A3_W-1:0]  j_cnt;
    logic [HID_W-1:0] h_cnt;
    logic [IW-1:0]    i_cnt;
    logic [KW-1:0]    k_cnt;
    logic [DW-1:0]    d_cnt;
    logic             j_wrap, i_wrap, h_wrap, k_wrap, d_wrap;
    logic             l1_adv, l2_adv, drain_adv, last_l1, last_l2;
    logic             unused_cnt;

    assign l1_adv    = (state_q == S_L1) && !stall;
    assign l2_adv    = (state_q == S_L2) && !stall;
    assign drain_adv = ((state_q == S_DRAIN1) || (state_q == S_DRAIN2)) && !stall;
    assign last_l1   = j_wrap && i_wrap;
    assign last_l2   = h_wrap && k_wrap;

    // Only the terminal flags of the outer/drain counters steer the FSM.
    assign unused_cnt = ^{i_cnt, k_cnt, d_cnt};

    wrap_counter #(.MOD(N_IN), .W(A3_W)) u_cnt_j (
        .clk_i(clk), .reset_i(reset), .en_i(l1_adv), .cnt_o(j_cnt), .wrap_o(j_wrap)
    );
    wrap_counter #(.MOD(N_HID), .W(IW)) u_cnt_i (
        .clk_i(clk), .reset_i(reset), .en_i(l1_adv && j_wrap), .cnt_o(i_cnt), .wrap_o(i_wrap)
    );
    wrap_counter #(.MOD(N_HID), .W(HID_W)) u_cnt_h (
        .clk_i(clk), .reset_i(reset), .en_i(l2_adv), .cnt_o(h_cnt), .wrap_o(h_wrap)
    );
    wrap_counter #(.MOD(N_OUT), .W(KW)) u_cnt_k (
        .clk_i(clk), .reset_i(reset), .en_i(l2_adv && h_wrap), .cnt_o(k_cnt), .wrap_o(k_wrap)
    );
    wrap_counter #(.MOD(DRAIN), .W(DW)) u_cnt_d (
        .clk_i(clk), .reset_i(reset), .en_i(drain_adv), .cnt_o(d_cnt), .wrap_o(d_wrap)
    );

    // Linear weight addresses; they return to 0 after the last term so the idle layer reads 0.
    always_comb begin
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        if (l1_adv) begin
            addr1_d = last_l1 ? '0 : addr1_q + 1'b1;
        end
        if (l2_adv) begin
            addr2_d = last_l2 ? '0 : addr2_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr1_q <= '0;
            addr2_q <= '0;
        end else begin
            state_q <= state_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        layer_sel = 1'b0;
        mac_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_L1;
            end
            S_L1: begin
                busy      = 1'b1;
                mac_start = j_wrap && !stall;
                if (l1_adv && last_l1) state_d = S_DRAIN1;
            end
            S_DRAIN1: begin
                busy = 1'b1;
                if (drain_adv && d_wrap) state_d = S_L2;
            end
            S_L2: begin
                busy      = 1'b1;
                layer_sel = 1'b1;
                mac_start = h_wrap && !stall;
                if (l2_adv && last_l2) state_d = S_DRAIN2;
            end
            S_DRAIN2: begin
                busy      = 1'b1;
                layer_sel = 1'b1;
                if (drain_adv && d_wrap) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign address_1 = addr1_q;
    assign address_3 = j_cnt;
    assign address_2 = addr2_q;
    assign hid_addr  = h_cnt;
    assign we_1      = 1'b0;
    assign we_2      = 1'b0;
    assign we_3      = 1'b0;
endmodule

// File: tb/tb_mlp_sequencer.sv
// Bench for mlp_sequencer at small sizes: every cycle is compared against an expected
// term list built from nested neuron/term loops, under directed and random start/stall/reset.
module tb_mlp_sequencer;
    localparam int NI  = 4;
    localparam int NH  = 3;
    localparam int NO  = 2;
    localparam int ND  = 1;
    localparam int LAT = NH*NI + NO*NH + 2*ND + 1;

    logic        clk = 1'b0;
    logic        reset, start, stall;
    logic        busy, done, layer_sel, mac_start, we_1, we_2, we_3;
    logic [17:0] address_1;
    logic [9:0]  address_3;
    logic [11:0] address_2;
    logic [7:0]  hid_addr;

    mlp_sequencer #(.N_IN(NI), .N_HID(NH), .N_OUT(NO), .DRAIN(ND)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .busy(busy), .done(done), .layer_sel(layer_sel),
        .address_1(address_1), .address_3(address_3), .address_2(address_2),
        .hid_addr(hid_addr), .mac_start(mac_start),
        .we_1(we_1), .we_2(we_2), .we_3(we_3)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit busy, done, lsel, mac, hold;
        int a1, a3, a2, hid;
    } exp_t;

    exp_t seq[$];
    int   pos = -1;
    int   n_checks = 0, n_fail = 0;
    int   lat_cnt = 0, stall_cnt = 0, mac_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t blank();
        exp_t e;
        e.busy = 0; e.done = 0; e.lsel = 0; e.mac = 0; e.hold = 0;
        e.a1 = 0; e.a3 = 0; e.a2 = 0; e.hid = 0;
        return e;
    endfunction

    // One entry per cycle in which the inference moves forward, in order.
    task automatic build_seq();
        exp_t e;
        for (int i = 0; i < NH; i++)
            for (int j = 0; j < NI; j++) begin
                e = blank(); e.busy = 1; e.hold = 1;
                e.a1 = i*NI + j; e.a3 = j; e.mac = (j == NI-1);
                seq.push_back(e);
            end
        for (int d = 0; d < ND; d++) begin
            e = blank(); e.busy = 1; e.hold = 1;
            seq.push_back(e);
        end
        for (int k = 0; k < NO; k++)
            for (int h = 0; h < NH; h++) begin
                e = blank(); e.busy = 1; e.hold = 1; e.lsel = 1;
                e.a2 = k*NH + h; e.hid = h; e.mac = (h == NH-1);
                seq.push_back(e);
            end
        for (int d = 0; d < ND; d++) begin
            e = blank(); e.busy = 1; e.hold = 1; e.lsel = 1;
            seq.push_back(e);
        end
        e = blank(); e.done = 1;
        seq.push_back(e);
    endtask

    task automatic step(input logic r, input logic s, input logic st);
        exp_t e;
        reset = r; start = s; stall = st;
        @(negedge clk);
        e = (pos < 0) ? blank() : seq[pos];
        if (e.hold && st) e.mac = 0;
        if (mac_start === 1'b1) mac_cnt++;
        check("busy",      busy,      e.busy);
        check("done",      done,      e.done);
        check("layer_sel", layer_sel, e.lsel);
        check("mac_start", mac_start, e.mac);
        check("address_1", address_1, e.a1);
        check("address_3", address_3, e.a3);
        check("address_2", address_2, e.a2);
        check("hid_addr",  hid_addr,  e.hid);
        check("we",        {we_1, we_2, we_3}, 0);
        if (e.done) begin
            check("latency",   lat_cnt, LAT + stall_cnt);
            check("mac_count", mac_cnt, NH + NO);
        end
        @(posedge clk);
        if (r) begin
            pos = -1;
        end else if (pos < 0) begin
            if (s) begin
                pos = 0; lat_cnt = 1; stall_cnt = 0; mac_cnt = 0;
            end
        end else if (e.hold && st) begin
            stall_cnt++; lat_cnt++;
        end else begin
            pos++; lat_cnt++;
            if (pos == seq.size()) pos = -1;
        end
        #1;
    endtask

    initial begin
        build_seq();
        reset = 1'b1; start = 1'b0; stall = 1'b0;

        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Plain run with start pulses while busy and during the done cycle.
        for (int c = 0; c < LAT + 4; c++)
            step(1'b0, (c == 0 || c == 5 || c == LAT), 1'b0);

        // Three-cycle stall on the first neuron's last pixel term.
        for (int c = 0; c < LAT + 7; c++)
            step(1'b0, (c == 0), (c >= NI && c < NI + 3));

        // Stalls in drain and layer 2, plus stall in idle together with start.
        for (int c = 0; c < LAT + 8; c++)
            step(1'b0, (c == 0), (c == 0 || c == NH*NI + 1 || c == NH*NI + 4 || c == LAT + 3));

        // Reset in the middle of layer 1, with start and stall asserted alongside it.
        for (int c = 0; c < 8; c++) step(1'b0, (c == 0), 1'b0);
        step(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < LAT + 3; c++) step(1'b0, (c == 1), 1'b0);

        for (int c = 0; c < 1500; c++)
            step(($urandom_range(99) == 0), ($urandom_range(7) == 0), ($urandom_range(3) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
